// File: rtl/sdf_r22_stage_if.sv
// Streaming sample bus for one radix-2^2 SDF stage: input samples, frame direction
// and registered output samples.
interface sdf_r22_stage_if #(
   parameter int WIDTH = 16
);
   logic             di_en;
   logic [WIDTH-1:0] di_re;
   logic [WIDTH-1:0] di_im;
   logic             inverse;
   logic             do_en;
   logic [WIDTH-1:0] do_re;
   logic [WIDTH-1:0] do_im;
   logic             do_sof;

   modport master (
      output di_en, di_re, di_im, inverse,
      input  do_en, do_re, do_im, do_sof
   );

   modport slave (
      input  di_en, di_re, di_im, inverse,
      output do_en, do_re, do_im, do_sof
   );
endinterface

// File: rtl/sdf_r22_stage.sv
// Radix-2^2 single-path delay-feedback butterfly stage with span M, optional /2 scaling
// and a per-frame -j/+j trivial twiddle on the odd-block difference outputs.
module sdf_r22_stage #(
   parameter int WIDTH = 16,
   parameter int N     = 256,
   parameter int M     = 2,
   parameter int SCALE = 0,
   parameter int MJ_EN = 1
) (
   input  logic           clock,
   input  logic           reset,
   sdf_r22_stage_if.slave bus
);
   localparam int LOG_N = $clog2(N);
   localparam int L     = $clog2(M);
   localparam logic [LOG_N-1:0] CNT_SET  = LOG_N'(M - 1);
   localparam logic [LOG_N-1:0] CNT_LAST = LOG_N'(N - 1);

   logic [LOG_N-1:0]   di_cnt_q, di_cnt_d;
   logic [LOG_N-1:0]   out_cnt_q, out_cnt_d;
   logic               sp_en_q, sp_en_d;
   logic               inv_in_q, inv_in_d;
   logic               inv_out_q, inv_out_d;
   logic               do_en_q, do_en_d;
   logic               do_sof_q, do_sof_d;
   logic [WIDTH-1:0]   do_re_q, do_re_d;
   logic [WIDTH-1:0]   do_im_q, do_im_d;
   logic [2*WIDTH-1:0] dbuf_q [M];
   logic [2*WIDTH-1:0] dbuf_d [M];

   logic               bf, mj_blk, sp_set, frame_inv;
   logic [WIDTH-1:0]   head_re, head_im, cand_re, cand_im, push_re, push_im;
   logic signed [WIDTH:0] sum_re, sum_im, dif_re, dif_im;

   function automatic logic [WIDTH-1:0] fit(input logic [WIDTH:0] s);
      logic [WIDTH:0] r;
      r = s + (WIDTH+1)'(1);
      return (SCALE != 0) ? WIDTH'(r >> 1) : WIDTH'(s);
   endfunction

   // The odd 2M block of each 4M group exists only when N >= 4M.
   generate
      if (LOG_N >= L + 2) begin : g_mj
         assign mj_blk = out_cnt_q[L+1] & out_cnt_q[L];
      end else begin : g_no_mj
         assign mj_blk = 1'b0;
      end
   endgenerate

   always_comb begin
      bf      = di_cnt_q[L];
      head_re = dbuf_q[M-1][2*WIDTH-1:WIDTH];
      head_im = dbuf_q[M-1][WIDTH-1:0];
      sum_re  = $signed({head_re[WIDTH-1], head_re}) + $signed({bus.di_re[WIDTH-1], bus.di_re});
      sum_im  = $signed({head_im[WIDTH-1], head_im}) + $signed({bus.di_im[WIDTH-1], bus.di_im});
      dif_re  = $signed({head_re[WIDTH-1], head_re}) - $signed({bus.di_re[WIDTH-1], bus.di_re});
      dif_im  = $signed({head_im[WIDTH-1], head_im}) - $signed({bus.di_im[WIDTH-1], bus.di_im});
      cand_re = head_re;
      cand_im = head_im;
      push_re = bus.di_re;
      push_im = bus.di_im;
      if (bf) begin
         cand_re = fit(sum_re);
         cand_im = fit(sum_im);
         push_re = fit(dif_re);
         push_im = fit(dif_im);
      end else if ((MJ_EN != 0) && mj_blk) begin
         // +j: (-b, a); -j: (b, -a); negation wraps at WIDTH bits
         if (inv_out_q) begin
            cand_re = -head_im;
            cand_im = head_re;
         end else begin
            cand_re = head_im;
            cand_im = -head_re;
         end
      end
      dbuf_d[0] = {push_re, push_im};
      for (int unsigned i = 1; i < M; i++) begin
         dbuf_d[i] = dbuf_q[i-1];
      end
   end

   always_comb begin
      di_cnt_d  = bus.di_en ? di_cnt_q + LOG_N'(1) : '0;
      sp_set    = bus.di_en && (di_cnt_q == CNT_SET);
      sp_en_d   = sp_en_q;
      if (sp_en_q && (out_cnt_q == CNT_LAST)) sp_en_d = 1'b0;
      if (sp_set) sp_en_d = 1'b1;
      out_cnt_d = sp_en_q ? out_cnt_q + LOG_N'(1) : '0;
      // The output frame keeps its own copy so a following frame's capture cannot leak in.
      frame_inv = (di_cnt_q == '0) ? bus.inverse : inv_in_q;
      inv_in_d  = (bus.di_en && (di_cnt_q == '0)) ? bus.inverse : inv_in_q;
      inv_out_d = sp_set ? frame_inv : inv_out_q;
      do_en_d   = sp_en_q;
      do_sof_d  = sp_en_q && (out_cnt_q == '0);
      do_re_d   = sp_en_q ? cand_re : do_re_q;
      do_im_d   = sp_en_q ? cand_im : do_im_q;
   end

   always_ff @(posedge clock) begin
      for (int unsigned i = 0; i < M; i++) begin
         dbuf_q[i] <= dbuf_d[i];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         di_cnt_q  <= '0;
         out_cnt_q <= '0;
         sp_en_q   <= 1'b0;
         inv_in_q  <= 1'b0;
         inv_out_q <= 1'b0;
         do_en_q   <= 1'b0;
         do_sof_q  <= 1'b0;
         do_re_q   <= '0;
         do_im_q   <= '0;
      end else begin
         di_cnt_q  <= di_cnt_d;
         out_cnt_q <= out_cnt_d;
         sp_en_q   <= sp_en_d;
         inv_in_q  <= inv_in_d;
         inv_out_q <= inv_out_d;
         do_en_q   <= do_en_d;
         do_sof_q  <= do_sof_d;
         do_re_q   <= do_re_d;
         do_im_q   <= do_im_d;
      end
   end

   assign bus.do_en  = do_en_q;
   assign bus.do_sof = do_sof_q;
   assign bus.do_re  = do_re_q;
   assign bus.do_im  = do_im_q;
endmodule

// File: doc/sdf_r22_stage.md
# sdf_r22_stage

Parametrised radix-2² single-path delay-feedback (SDF) butterfly stage for an N-point streaming FFT, with configurable butterfly span M, selectable output scaling and a per-frame forward/inverse trivial-twiddle (∓j) mode. It sits in the FFT pipeline between twiddle multipliers, one instance per stage, and is the common replacement for fixed-size, fixed-span stage modules. It consumes one complex sample per cycle and produces one complex sample per cycle, in frame order, after a fixed latency.

## Interface
- WIDTH, 16, two's-complement bit width of each real/imag component
- N, 256, frame length in samples; power of two, 4..4096
- M, 2, butterfly span and delay-buffer depth; power of two, 1..N/2
- SCALE, 0, 0 = no scaling (wrap on overflow); 1 = divide butterfly outputs by 2 with round-half-up
- MJ_EN, 1, 1 = apply trivial twiddle to the qualifying difference outputs; 0 = never apply it
- clock  in  1  master clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- di_en  in  1  input sample valid; high for N consecutive cycles per frame
- di_re / di_im  in  WIDTH each  input sample
- inverse  in  1  0 = apply −j, 1 = apply +j; sampled at the first di_en cycle of each frame
- do_en  out  1  output sample valid
- do_re / do_im  out  WIDTH each  output sample
- do_sof  out  1  one-cycle pulse with do_en on output position 0 of each frame

## Operation
- Input counter di_cnt (log2 N bits): increments on each di_en cycle and wraps mod N; cleared on any cycle with di_en low. Let L = log2 M and bf = di_cnt[L].
- Delay buffer: an M-deep FIFO of 2·WIDTH bits that shifts on every clock. It is not reset.
- bf = 0 (fill): the input goes into the buffer, and the buffer head is the candidate output.
- bf = 1 (butterfly): x0 = buffer head, x1 = input. y0 = x0 + x1 is the candidate output, and y1 = x0 − x1 goes into the buffer.
- Arithmetic is done at WIDTH+1 bits.
  - SCALE = 0: take the low WIDTH bits, so results wrap.
  - SCALE = 1: result = (s + 1) >>> 1, arithmetic shift.
- Output counter and sp_en:
  - sp_en sets on the cycle after di_en with di_cnt == M−1.
  - sp_en clears on the cycle after out_cnt == N−1.
  - If set and clear coincide, set wins (back-to-back frames).
  - out_cnt (log2 N bits) increments while sp_en is high and is 0 otherwise.
- Trivial twiddle:
  - Applies when MJ_EN = 1, the output is a fill-phase (difference) output, and out_cnt[L+1:L] == 2'b11. This needs N ≥ 4M; with N = 2M it never applies.
  - −j·(a + jb) = (b, −a). +j·(a + jb) = (−b, a).
  - Negating −2^(WIDTH−1) wraps to itself.
- inverse is captured into a frame register on the cycle with di_en high and di_cnt == 0. The output path uses the register value captured for the frame being emitted; a mid-frame change of inverse has no effect.
- The output is registered: do_re/do_im/do_en/do_sof are updated every clock from the candidate output, sp_en, and (out_cnt == 0 && sp_en).
- Output data while do_en = 0 holds its last value. It is don't-care for checking.
- reset clears di_cnt, out_cnt, sp_en, the inverse register, do_en = 0, do_sof = 0, do_re = do_im = 0.

## Timing
- Latency: if the first di_en of a frame is cycle 0, output position p is presented on cycle M + 1 + p with do_en = 1.
- The M leading fill cycles produce no output. The stage drains for M+1 cycles after the last input with no further di_en needed.
- Output order per 2M block: M sums (positions k), then M differences (positions k+M), with ∓j applied as defined.
- Back-to-back frames (di_en continuous): do_en stays high continuously, do_sof pulses every N cycles, and out_cnt wraps without a gap.
- di_en drop mid-frame: the input counter clears immediately. The current output frame still runs to out_cnt == N−1, and its data from that point is don't-care.
- Reset mid-frame: outputs read as reset values on the cycle after reset is sampled. The frame is abandoned. Data emitted during the first M+1 output positions of the next frame after reset is valid, because the delay buffer refills before use.

## Test plan
All scenarios use N=16, M=4, WIDTH=16.
- Reset: assert reset for 2 cycles with di_en = 1 -> do_en = 0, do_sof = 0, do_re = do_im = 0 on every cycle after the first sampled edge.
- Impulse, SCALE=0, inverse=0: frame with x[0] = (1000,0) and all other samples 0 -> outputs at cycles 5..20 (do_sof at cycle 5); position 0 = (1000,0), position 4 = (1000,0), all others (0,0).
- Twiddle and inverse: x[8] = (1000,200) -> position 8 = (1000,200), position 12 = (200,−1000). Repeat with inverse=1 sampled at cycle 0 and toggled mid-frame -> position 12 = (−200,1000).
- Scaling, SCALE=1: x[0] = (3,−3), x[4] = (0,0) -> position 0 = (2,−1), position 4 = (2,−1). Also x[0] = x[4] = (32767,32767) -> position 0 = (32767,32767), position 4 = (0,0).
- Overflow, SCALE=0: x[0] = (32767,0), x[4] = (1,0) -> position 0 = (−32768,0), position 4 = (32766,0). Also x[12] = (−32768,0) with MJ -> position 12 = (0,−32768).
- Back-to-back frames: 3 consecutive frames with no gap -> do_en high for 48 consecutive cycles from cycle 5, do_sof at cycles 5, 21 and 37, and each frame's data matches an independent single-frame run.
